sram_port_ctrl: RTL

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

---
 rtl/sram_port_pkg.sv | 16 +
 rtl/sram_rsp_fifo.sv | 43 ++++
 rtl/sram_port_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/sram_port_pkg.sv
// sram_port_pkg: shared response entry, tracking entry and parameter limits for sram_port_ctrl
package sram_port_pkg;
  localparam int unsigned MinLatency = 1;
  localparam int unsigned MaxLatency = 4;
  localparam int unsigned MinRspDepth = 1;
  localparam int unsigned MaxDataWidth = 1024;
  typedef struct packed {
    logic [MaxDataWidth-1:0] rdata;
    logic err;
  } rsp_entry_t;
  typedef struct packed {
    logic valid;
    logic err;
    logic zero;
  } track_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: in-order response FIFO with occupancy count
module sram_rsp_fifo #(
  parameter int unsigned Depth = 2,
  parameter type entry_t = logic,
  localparam int unsigned PtrWidth = Depth > 1 ? $clog2(Depth) : 1,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  entry_t              data_i,
  input  logic                pop_i,
  output entry_t              data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] count_o
);
  entry_t mem_q [Depth];
  logic [PtrWidth-1:0] wr_q, rd_q;
  logic do_push, do_pop;
  function automatic logic [PtrWidth-1:0] inc(input logic [PtrWidth-1:0] p);
    return p == PtrWidth'(Depth - 1) ? '0 : p + 1'b1;
  endfunction
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign full_o = count_o == CntWidth'(Depth);
  assign empty_o = count_o == '0;
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      count_o <= '0;
    end else begin
      wr_q <= do_push ? inc(wr_q) : wr_q;
      rd_q <= do_pop ? inc(rd_q) : rd_q;
      count_o <= count_o + CntWidth'(do_push) - CntWidth'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: credit-gated single-port SRAM request/response controller
// SRAM_PORT_CTRL_WRITE_ACK_EN: writes also consume a response slot and return an ack
module sram_port_ctrl
  import sram_port_pkg::*;
#(
  parameter int unsigned NumWords = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency = 1,
  parameter int unsigned RspDepth = Latency + 1,
  localparam int unsigned BeWidth = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned AddrWidth = NumWords > 1 ? $clog2(NumWords) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);
`ifdef SRAM_PORT_CTRL_WRITE_ACK_EN
  localparam bit WriteAck = 1'b1;
`else
  localparam bit WriteAck = 1'b0;
`endif
  localparam int unsigned CntWidth = $clog2(RspDepth + 1);
  if (Latency < MinLatency || Latency > MaxLatency) begin : g_bad_latency
    $error("sram_port_ctrl: Latency out of range");
  end
  if (RspDepth < MinRspDepth || DataWidth > MaxDataWidth) begin : g_bad_depth
    $error("sram_port_ctrl: RspDepth or DataWidth out of range");
  end
  track_t sr_q [Latency];
  track_t tail;
  rsp_entry_t push_data, pop_data;
  logic [CntWidth-1:0] count;
  logic [2:0] inflight;
  logic in_range, pop, credit, accept, full, empty, unused_fifo;
  assign in_range = 32'(req_addr_i) < NumWords;
  assign pop = rsp_valid_o && rsp_ready_i;
  // a pop in this cycle frees a slot for a same-cycle accept
  assign credit = (32'(inflight) + 32'(count) < RspDepth) || pop;
  assign req_ready_o = (req_we_i && !WriteAck) || credit;
  assign accept = req_valid_i && req_ready_o;
  assign sram_req_o = accept && in_range;
  assign sram_we_o = req_we_i;
  assign sram_addr_o = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o = req_be_i;
  assign tail = sr_q[Latency-1];
  assign push_data = '{rdata: tail.zero ? '0 : MaxDataWidth'(sram_rdata_i), err: tail.err};
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(Latency); i++) inflight = inflight + 3'(sr_q[i].valid);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Latency); i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= '{valid: accept && (!req_we_i || WriteAck), err: !in_range, zero: req_we_i || !in_range};
      for (int i = 1; i < int'(Latency); i++) sr_q[i] <= sr_q[i-1];
    end
  end
  sram_rsp_fifo #(.Depth(RspDepth), .entry_t(rsp_entry_t)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (tail.valid),
    .data_i (push_data),
    .pop_i  (pop),
    .data_o (pop_data),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );
  assign rsp_valid_o = !empty;
  assign rsp_rdata_o = empty ? '0 : pop_data.rdata[DataWidth-1:0];
  assign rsp_err_o = !empty && pop_data.err;
  assign unused_fifo = ^{full, pop_data.rdata};
endmodule
